// File: rtl/shift_unit_pipe.sv
// Pipelined multi-mode barrel shifter: one register stage per shift-amount bit,
// LSB stage first, with carry/zero flags and a valid/ready handshake.
module shift_unit_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] bus_i,
  input  logic [SHW-1:0]   shift_i,
  input  logic [2:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam int STAGES = SHW;

  localparam logic [2:0] M_SLL = 3'd0;
  localparam logic [2:0] M_SRL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  // One stage step: shift/rotate d by s when en is set; returns {carry, data}.
  // Carry is taken from this stage's input so the last non-zero stage wins.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic             c,
    input logic             en,
    input logic [SHW-1:0]   s
  );
    logic signed [WIDTH-1:0] ds;
    logic [SHW-1:0]          il;
    logic [SHW-1:0]          ir;
    logic [WIDTH-1:0]        r;
    logic                    co;
    ds = d;
    il = SHW'(0) - s;
    ir = s - SHW'(1);
    r  = d;
    co = c;
    if (en) begin
      case (mode)
        M_SLL: begin r = d << s;               co = d[il]; end
        M_SRL: begin r = d >> s;               co = d[ir]; end
        M_SRA: begin r = ds >>> s;             co = d[ir]; end
        M_ROL: begin r = (d << s) | (d >> il); co = d[il]; end
        M_ROR: begin r = (d >> s) | (d << il); co = d[ir]; end
        default: ;
      endcase
    end
    return {co, r};
  endfunction

  logic [WIDTH-1:0] data_p  [STAGES];
  logic [SHW-1:0]   rem_p   [STAGES];
  logic [2:0]       mode_p  [STAGES];
  logic             carry_p [STAGES];
  logic             vld_p   [STAGES];

  logic [WIDTH-1:0] data_in  [STAGES];
  logic [SHW-1:0]   rem_in   [STAGES];
  logic [2:0]       mode_in  [STAGES];
  logic             carry_in [STAGES];
  logic             vld_in   [STAGES];

  logic [WIDTH-1:0] data_n  [STAGES];
  logic [SHW-1:0]   rem_n   [STAGES];
  logic [2:0]       mode_n  [STAGES];
  logic             carry_n [STAGES];
  logic             vld_n   [STAGES];

  logic [WIDTH:0]   step;
  logic             advance;

  assign advance = !vld_p[STAGES-1] || ready_i;
  assign ready_o = advance;

  always_comb begin
    data_in[0]  = bus_i;
    rem_in[0]   = shift_i;
    mode_in[0]  = mode_i;
    carry_in[0] = 1'b0;
    vld_in[0]   = valid_i;
    for (int k = 1; k < STAGES; k++) begin
      data_in[k]  = data_p[k-1];
      rem_in[k]   = rem_p[k-1];
      mode_in[k]  = mode_p[k-1];
      carry_in[k] = carry_p[k-1];
      vld_in[k]   = vld_p[k-1];
    end
  end

  always_comb begin
    step = '0;
    for (int k = 0; k < STAGES; k++) begin
      step       = shift_step(data_in[k], mode_in[k], carry_in[k], rem_in[k][0],
                              SHW'(1) << k);
      data_n[k]  = step[WIDTH-1:0];
      carry_n[k] = step[WIDTH];
      rem_n[k]   = rem_in[k] >> 1;
      mode_n[k]  = mode_in[k];
      vld_n[k]   = vld_in[k];
    end
  end

  // Stage registers: the whole pipe moves together or holds together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        data_p[k]  <= '0;
        rem_p[k]   <= '0;
        mode_p[k]  <= '0;
        carry_p[k] <= 1'b0;
        vld_p[k]   <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_n[k];
        if (vld_n[k]) begin
          data_p[k]  <= data_n[k];
          rem_p[k]   <= rem_n[k];
          mode_p[k]  <= mode_n[k];
          carry_p[k] <= carry_n[k];
        end
      end
    end
  end

  assign valid_o = vld_p[STAGES-1];
  assign bus_o   = data_p[STAGES-1];
  assign carry_o = carry_p[STAGES-1];
  assign zero_o  = vld_p[STAGES-1] && (data_p[STAGES-1] == '0);

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed vector table, hand-written corner
// sequences and a randomized scoreboard against a plain-arithmetic model.
module tb_shift_unit_pipe;
  localparam int W   = 32;
  localparam int SHW = 5;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  bus_i;
  logic [SHW-1:0] shift_i;
  logic [2:0]    mode_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  bus_o;
  logic          carry_o;
  logic          zero_o;

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .bus_i(bus_i), .shift_i(shift_i), .mode_i(mode_i), .valid_o(valid_o),
    .ready_i(ready_i), .bus_o(bus_o), .carry_o(carry_o), .zero_o(zero_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stall_seen = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [31:0] bus;
    logic [4:0]  sh;
    logic [2:0]  mode;
    logic [31:0] eb;
    logic        ec;
    logic        ez;
  } vec_t;
  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Reference: direct formulas from the shift definitions, {carry, result}.
  function automatic logic [W:0] model(input logic [31:0] b, input int n, input logic [2:0] m);
    logic [63:0] w;
    logic [31:0] r;
    logic        c;
    r = b;
    c = 1'b0;
    case (m)
      3'd0: begin r = b << n; if (n > 0) c = b[32-n]; end
      3'd1: begin r = b >> n; if (n > 0) c = b[n-1]; end
      3'd2: begin r = $signed(b) >>> n; if (n > 0) c = b[n-1]; end
      3'd3: begin w = {b, b} << n; r = w[63:32]; if (n > 0) c = r[0]; end
      3'd4: begin w = {b, b} >> n; r = w[31:0]; if (n > 0) c = r[31]; end
      default: begin r = b; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  logic        have_prev = 1'b0;
  logic [31:0] prev_bus;
  logic        prev_carry;

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (valid_o && !ready_i) begin
        stall_seen++;
        check("stall_ready_o", ready_o, 0);
        if (have_prev) begin
          check("stall_hold_bus", bus_o, prev_bus);
          check("stall_hold_carry", carry_o, prev_carry);
        end
        prev_bus   = bus_o;
        prev_carry = carry_o;
        have_prev  = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got 0x%08h, want no output", bus_o);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sb_bus", bus_o, e[W-1:0]);
          check("sb_carry", carry_o, e[W]);
          check("sb_zero", zero_o, e[W-1:0] == 0);
        end
      end
      if (valid_i && ready_o)
        exp_q.push_back(model(bus_i, int'(shift_i), mode_i));
    end
  end

  task automatic send(input logic [31:0] b, input logic [4:0] s, input logic [2:0] m);
    int   g;
    logic acc;
    g = 0;
    valid_i = 1'b1; bus_i = b; shift_i = s; mode_i = m;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      g++;
    end while (!acc && g < 200);
    #1;
    valid_i = 1'b0;
    bus_i   = $urandom;
    shift_i = 5'($urandom);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_accept: got no ready_o in %0d cycles, want accept", g);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    valid_i = 1'b1; bus_i = v.bus; shift_i = v.sh; mode_i = v.mode;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check($sformatf("vec%0d_early_valid", idx), valid_o, 0);
    repeat (SHW - 1) @(posedge clk);
    #1;
    check($sformatf("vec%0d_valid", idx), valid_o, 1);
    check($sformatf("vec%0d_bus", idx), bus_o, v.eb);
    check($sformatf("vec%0d_carry", idx), carry_o, v.ec);
    check($sformatf("vec%0d_zero", idx), zero_o, v.ez);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h8000_0001, 5'd1,  3'd0, 32'h0000_0002, 1'b1, 1'b0};
    vecs[1]  = '{32'hF000_0010, 5'd4,  3'd2, 32'hFF00_0001, 1'b0, 1'b0};
    vecs[2]  = '{32'hF000_0010, 5'd4,  3'd1, 32'h0F00_0001, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0001, 5'd1,  3'd4, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4]  = '{32'h8000_0000, 5'd31, 3'd3, 32'h4000_0000, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0002, 5'd31, 3'd0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  3'd0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[7]  = '{32'hDEAD_BEEF, 5'd0,  3'd1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[8]  = '{32'hDEAD_BEEF, 5'd0,  3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[9]  = '{32'hDEAD_BEEF, 5'd0,  3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[10] = '{32'hDEAD_BEEF, 5'd0,  3'd4, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[11] = '{32'hDEAD_BEEF, 5'd0,  3'd7, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[12] = '{32'hDEAD_BEEF, 5'd13, 3'd5, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[13] = '{32'hDEAD_BEEF, 5'd31, 3'd6, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[14] = '{32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[15] = '{32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[16] = '{32'h1234_5678, 5'd8,  3'd3, 32'h3456_7812, 1'b0, 1'b0};
    vecs[17] = '{32'h1234_5678, 5'd4,  3'd4, 32'h8123_4567, 1'b1, 1'b0};
    vecs[18] = '{32'h0000_0000, 5'd3,  3'd0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[19] = '{32'h0000_000F, 5'd4,  3'd1, 32'h0000_0000, 1'b1, 1'b1};
    vecs[20] = '{32'h7FFF_FFFF, 5'd31, 3'd2, 32'h0000_0000, 1'b1, 1'b1};

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    bus_i = '0; shift_i = '0; mode_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_bus_o", bus_o, 0);
    check("rst_carry_o", carry_o, 0);
    check("rst_zero_o", zero_o, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_o", ready_o, 1);

    for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

    // Back-to-back SLL pair: second result zero with carry from bus[1].
    @(posedge clk); #1;
    send(32'h1, 5'd31, 3'd0);
    send(32'h2, 5'd31, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check("pair1_valid", valid_o, 1);
    check("pair1_bus", bus_o, 32'h8000_0000);
    check("pair1_carry", carry_o, 0);
    @(posedge clk); #1;
    check("pair2_valid", valid_o, 1);
    check("pair2_bus", bus_o, 32'h0);
    check("pair2_zero", zero_o, 1);
    check("pair2_carry", carry_o, 1);
    drain();

    // Eight consecutive operations with ready_i low for cycles 6-9.
    @(posedge clk); #1;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, 5'($urandom), 3'($urandom_range(0, 4)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("stall_cycles", stall_seen, 4);

    // Random traffic with random backpressure and idle gaps.
    begin
      logic done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 300; i++) begin
            send($urandom, 5'($urandom), 3'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1 ready_i = ($urandom_range(0, 3) != 0);
          end
        end
      join
    end
    ready_i = 1'b1;
    drain();

    // Reset with three operations in flight: nothing may come out.
    @(posedge clk); #1;
    send(32'hA5A5_0001, 5'd3, 3'd0);
    send(32'h0F0F_F0F0, 5'd7, 3'd3);
    send(32'h8000_0000, 5'd2, 3'd2);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    check("midrst_valid_o", valid_o, 0);
    check("midrst_bus_o", bus_o, 0);
    check("midrst_carry_o", carry_o, 0);
    check("midrst_ready_o", ready_o, 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (valid_o) seen++;
      end
      check("midrst_no_emit", seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
